resnet_tile_sched: RTL and testbench
====================================

# resnet_tile_sched

Tile-level controller for the ResNet layer flow on the systolic core. For each of NUM_TILES tiles it:
- pulses the core's `seq_begin` and waits for `seq_done`;
- drains the 16 OP SRAM rows;
- adds the 4-bit residual per output lane, optionally applies ReLU, and streams each finished 128-bit row out with a valid/ready handshake.

It sits between the core, the residual SRAM and the downstream result buffer, and replaces the residual/ReLU post-processing the bench has done by hand until now.

## Interface
Parameters:
- NUM_TILES, 64, tiles per layer run
- ROWS, 16, OP SRAM rows per tile
- LANES, 8, output lanes per row
- PSUM_BW, 16, bits per lane in OP SRAM word
- RES_BW, 4, bits per residual lane (unsigned)
- TIMEOUT, 32768, max cycles to wait for core_done

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a layer run
- busy  out  1  high from run accept until return to IDLE
- done  out  1  one-cycle pulse after last row of last tile accepted
- err_timeout  out  1  sticky; set on core_done timeout, cleared on next accepted start
- tile_idx  out  $clog2(NUM_TILES)  current tile
- core_begin  out  1  to core seq_begin; one-cycle pulse
- core_done  in  1  from core seq_done
- op_cen  out  1  OP SRAM chip enable, active-low
- op_wen  out  1  OP SRAM write enable; tied high (read only)
- op_addr  out  $clog2(ROWS)  OP SRAM row
- op_q  in  LANES*PSUM_BW  OP SRAM read data, valid 1 cycle after op_cen=0
- res_cen  out  1  residual SRAM enable, active-low
- res_addr  out  $clog2(NUM_TILES*ROWS)  tile_idx*ROWS+row
- res_q  in  LANES*RES_BW  residual read data, same latency as op_q
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*PSUM_BW  post-processed row
- out_addr  out  $clog2(NUM_TILES*ROWS)  global row index of out_data

## Operation
States: IDLE, KICK, WAIT, RD, CALC, PUSH, NEXT.
- **IDLE.** start=1 clears tile_idx, row and err_timeout, then goes to KICK. start outside IDLE is ignored.
- **KICK** (1 cycle). core_begin=1, timeout counter cleared, go to WAIT.
- **WAIT.** core_done=1 goes to RD with row=0.
  - Counter increments each WAIT cycle; when it reaches TIMEOUT-1 without core_done: err_timeout=1, go to IDLE, no done pulse.
  - core_done in any other state is ignored.
- **RD** (1 cycle). op_cen=0, res_cen=0, op_addr=row, res_addr=tile_idx*ROWS+row.
- **CALC** (1 cycle). Capture op_q and res_q and compute lanes.
- **PUSH.** out_valid=1. out_data and out_addr are registered and held stable until out_valid && out_ready.
  - On handshake: row==ROWS-1 goes to NEXT, else row+1 and go to RD.
- **NEXT** (1 cycle). tile_idx==NUM_TILES-1 pulses done and goes to IDLE; else tile_idx+1 and go to KICK.

Arithmetic, per lane j:
- s = op_q[PSUM_BW*j +: PSUM_BW] + zero-extended res_q[RES_BW*j +: RES_BW].
- Two's-complement, PSUM_BW-bit result, wraps with no saturation.
- ReLU per Configuration.

## Timing
- Reset values: busy=0, done=0, err_timeout=0, tile_idx=0, core_begin=0, op_cen=1, op_wen=1, op_addr=0, res_cen=1, res_addr=0, out_valid=0, out_data=0, out_addr=0. State is IDLE.
- start high at edge N: busy=1 and core_begin=1 during cycle N+1.
- With out_ready=1 constantly, each row costs 3 cycles (RD, CALC, PUSH). A tile costs 2+ROWS*3+W cycles, where W is the number of WAIT cycles.
- done is asserted in the cycle after the final handshake. busy falls in the same cycle as done.
- Reset asserted mid-run returns immediately to reset values. A pending out_valid is dropped. The core is not re-kicked.
- out_ready high before out_valid has no effect; no combinational path from out_ready to out_valid.

## Configuration
- SCHED_RELU_EN defined: a lane with s[PSUM_BW-1]=1 outputs 0.
- SCHED_RELU_EN undefined: the lane outputs s unchanged.

## Test plan
- **Single-row arithmetic.** NUM_TILES=1, lane0 op=16'h0005, res=4'h3, lane1 op=16'hFFF0, res=4'hF.
  - Expect lane0=16'h0008.
  - Expect lane1=16'h0000 with ReLU, 16'hFFFF without.
- **Wrap.** lane op=16'h7FFF, res=4'h1 -> 16'h0000 with ReLU, 16'h8000 without.
- **Full run.** NUM_TILES=64, out_ready=1, core_done 10 cycles after each core_begin.
  - Expect 64 core_begin pulses, 1024 rows with out_addr 0..1023 in order, and one done pulse.
- **Backpressure.** out_ready low 7 cycles during PUSH -> out_data and out_addr stable, row not advanced, no duplicate or lost rows.
- **Timeout and restart.** core_done never asserted -> err_timeout=1 after TIMEOUT WAIT cycles, state IDLE, no done. Next start clears err_timeout.
- **Abort and ignore.** Reset asserted mid-PUSH on tile 5 -> all outputs at reset values next cycle. start and core_done pulses during PUSH -> ignored.

Source files
------------

// File: rtl/resnet_tile_sched_if.sv
// resnet_tile_sched_if: result-row stream from the tile scheduler to the
// downstream result buffer. The scheduler is the master (drives valid, data and
// address); the buffer is the slave (drives ready).
`timescale 1ns/1ps
interface resnet_tile_sched_if #(
    parameter int LANES   = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_W  = 10
);
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*PSUM_BW-1:0]   out_data;
    logic [ADDR_W-1:0]          out_addr;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        output out_ready
    );
endinterface

// File: rtl/resnet_tile_sched.sv
// resnet_tile_sched: tile-level controller for the ResNet layer flow.
// For every tile it kicks the systolic core, waits for completion (with a
// timeout), then walks the OP SRAM rows, adds the unsigned residual per lane
// and streams each finished row to the result buffer.
// Optional feature: define SCHED_RELU_EN to force lanes with a negative sum to 0.
`timescale 1ns/1ps
module resnet_tile_sched #(
    parameter int NUM_TILES = 64,
    parameter int ROWS      = 16,
    parameter int LANES     = 8,
    parameter int PSUM_BW   = 16,
    parameter int RES_BW    = 4,
    parameter int TIMEOUT   = 32768,
    localparam int TILE_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int ADDR_W   = (NUM_TILES * ROWS > 1) ? $clog2(NUM_TILES * ROWS) : 1,
    localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1,
    localparam int DATA_W   = LANES * PSUM_BW,
    localparam int RESQ_W   = LANES * RES_BW
) (
    input  logic                clk,
    input  logic                reset,

    // Run control
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err_timeout,
    output logic [TILE_W-1:0]   tile_idx,

    // Systolic core sequencing
    output logic                core_begin,
    input  logic                core_done,

    // OP SRAM (read only)
    output logic                op_cen,
    output logic                op_wen,
    output logic [ROW_W-1:0]    op_addr,
    input  logic [DATA_W-1:0]   op_q,

    // Residual SRAM
    output logic                res_cen,
    output logic [ADDR_W-1:0]   res_addr,
    input  logic [RESQ_W-1:0]   res_q,

    // Result stream
    resnet_tile_sched_if.master out_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_WAIT,
        S_RD,
        S_CALC,
        S_PUSH,
        S_NEXT
    } state_t;

    state_t              state_q,    state_d;
    logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
    logic [ROW_W-1:0]    row_q,      row_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                err_q,      err_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;

    logic                last_row;
    logic                last_tile;
    logic                timeout_hit;
    logic [ADDR_W-1:0]   row_gaddr;

    // Residual add per lane: the residual is unsigned and zero-extended, the
    // sum wraps at PSUM_BW bits; optionally negative lanes are clamped to 0.
    function automatic logic [DATA_W-1:0] post_proc(
        input logic [DATA_W-1:0] op_word,
        input logic [RESQ_W-1:0] res_word
    );
        logic [DATA_W-1:0]  row;
        logic [PSUM_BW-1:0] s;
        row = '0;
        for (int j = 0; j < LANES; j++) begin
            s = op_word[PSUM_BW*j +: PSUM_BW]
              + PSUM_BW'(res_word[RES_BW*j +: RES_BW]);
`ifdef SCHED_RELU_EN
            if (s[PSUM_BW-1]) begin
                s = '0;
            end
`else
            s = s;
`endif
            row[PSUM_BW*j +: PSUM_BW] = s;
        end
        return row;
    endfunction

    assign last_row    = (row_q == ROW_W'(ROWS - 1));
    assign last_tile   = (tile_idx_q == TILE_W'(NUM_TILES - 1));
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign row_gaddr   = ADDR_W'(tile_idx_q) * ADDR_W'(ROWS) + ADDR_W'(row_q);

    // Next-state and datapath update for the tile/row sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch can be inferred.
        state_d    = state_q;
        tile_idx_d = tile_idx_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tile_idx_d = '0;
                    row_d      = '0;
                    err_d      = 1'b0;
                    state_d    = S_KICK;
                end
            end

            S_KICK: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (core_done) begin
                    row_d   = '0;
                    state_d = S_RD;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RD: begin
                state_d = S_CALC;
            end

            S_CALC: begin
                out_data_d = post_proc(op_q, res_q);
                out_addr_d = row_gaddr;
                state_d    = S_PUSH;
            end

            S_PUSH: begin
                if (out_if.out_ready) begin
                    if (last_row) begin
                        state_d = S_NEXT;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_RD;
                    end
                end
            end

            S_NEXT: begin
                if (last_tile) begin
                    state_d = S_IDLE;
                end else begin
                    tile_idx_d = tile_idx_q + 1'b1;
                    state_d    = S_KICK;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending result row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tile_idx_q <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            state_q    <= state_d;
            tile_idx_q <= tile_idx_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
        end
    end

    // Outputs are decoded from registered state only, so out_ready never
    // reaches out_valid combinationally.
    assign done        = (state_q == S_NEXT) && last_tile;
    assign busy        = (state_q != S_IDLE) && !done;
    assign err_timeout = err_q;
    assign tile_idx    = tile_idx_q;
    assign core_begin  = (state_q == S_KICK);

    assign op_cen      = (state_q != S_RD);
    assign op_wen      = 1'b1;
    assign op_addr     = row_q;
    assign res_cen     = (state_q != S_RD);
    assign res_addr    = row_gaddr;

    assign out_if.out_valid = (state_q == S_PUSH);
    assign out_if.out_data  = out_data_q;
    assign out_if.out_addr  = out_addr_q;

endmodule

// File: tb/tb_resnet_tile_sched.sv
// tb_resnet_tile_sched: scoreboard bench for resnet_tile_sched. Expected rows
// are queued when a run is started; a monitor pops and compares them whenever
// the scheduler presents a result row. Core and SRAMs are small bench models.
`timescale 1ns/1ps
module tb_resnet_tile_sched;

    localparam int NUM_TILES  = 64;
    localparam int ROWS       = 16;
    localparam int LANES      = 8;
    localparam int PSUM_BW    = 16;
    localparam int RES_BW     = 4;
    localparam int TIMEOUT    = 32768;
    localparam int TILE_W     = 6;
    localparam int ROW_W      = 4;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = LANES * PSUM_BW;
    localparam int RESQ_W     = LANES * RES_BW;
    localparam int TOTAL_ROWS = NUM_TILES * ROWS;
    localparam int CORE_LAT   = 10;

    localparam logic [DATA_W-1:0] GARBAGE_OP  = {8{16'hA5C3}};
    localparam logic [RESQ_W-1:0] GARBAGE_RES = 32'h5A5A5A5A;

    // Directed row 0: lanes 7..0.
    localparam logic [DATA_W-1:0] ROW0_OP  = {16'h7FF0, 16'h00FF, 16'hFFFF, 16'h8000,
                                              16'h1234, 16'h7FFF, 16'hFFF0, 16'h0005};
    localparam logic [RESQ_W-1:0] ROW0_RES = 32'hF11F01F3;
`ifdef SCHED_RELU_EN
    localparam logic [DATA_W-1:0] ROW0_EXP = {16'h7FFF, 16'h0100, 16'h0000, 16'h0000,
                                              16'h1234, 16'h0000, 16'h0000, 16'h0008};
    localparam bit RELU = 1'b1;
`else
    localparam logic [DATA_W-1:0] ROW0_EXP = {16'h7FFF, 16'h0100, 16'h0000, 16'h800F,
                                              16'h1234, 16'h8000, 16'hFFFF, 16'h0008};
    localparam bit RELU = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_row_t;

    logic               clk;
    logic               reset;
    logic               start;
    logic               busy;
    logic               done;
    logic               err_timeout;
    logic [TILE_W-1:0]  tile_idx;
    logic               core_begin;
    logic               core_done;
    logic               core_done_model;
    logic               core_done_extra;
    logic               op_cen;
    logic               op_wen;
    logic [ROW_W-1:0]   op_addr;
    logic [DATA_W-1:0]  op_q;
    logic               res_cen;
    logic [ADDR_W-1:0]  res_addr;
    logic [RESQ_W-1:0]  res_q;

    exp_row_t exp_q[$];
    int       checks      = 0;
    int       failures    = 0;
    int       core_begins = 0;
    int       done_pulses = 0;
    int       rows_seen   = 0;
    int       base        = 0;
    bit       core_respond;
    bit       expect_done = 1'b0;

    resnet_tile_sched_if #(.LANES(LANES), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W)) out_if ();

    resnet_tile_sched #(
        .NUM_TILES (NUM_TILES),
        .ROWS      (ROWS),
        .LANES     (LANES),
        .PSUM_BW   (PSUM_BW),
        .RES_BW    (RES_BW),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .tile_idx    (tile_idx),
        .core_begin  (core_begin),
        .core_done   (core_done),
        .op_cen      (op_cen),
        .op_wen      (op_wen),
        .op_addr     (op_addr),
        .op_q        (op_q),
        .res_cen     (res_cen),
        .res_addr    (res_addr),
        .res_q       (res_q),
        .out_if      (out_if)
    );

    assign core_done = core_done_model | core_done_extra;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // Stimulus data: row 0 is directed, the rest are a spread pattern.
    function automatic logic [DATA_W-1:0] op_word(input int g);
        logic [DATA_W-1:0] w;
        if (g == 0) return ROW0_OP;
        w = '0;
        for (int j = 0; j < LANES; j++) w[PSUM_BW*j +: PSUM_BW] = 16'(g * 389 + j * 8191 + 4660);
        return w;
    endfunction

    function automatic logic [RESQ_W-1:0] res_word(input int g);
        logic [RESQ_W-1:0] w;
        if (g == 0) return ROW0_RES;
        w = '0;
        for (int j = 0; j < LANES; j++) w[RES_BW*j +: RES_BW] = 4'(g * 7 + j * 5 + 1);
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] exp_word(input int g);
        logic [DATA_W-1:0] op, w;
        logic [RESQ_W-1:0] rs;
        int v;
        if (g == 0) return ROW0_EXP;
        op = op_word(g);
        rs = res_word(g);
        w  = '0;
        for (int j = 0; j < LANES; j++) begin
            v = (int'(op[PSUM_BW*j +: PSUM_BW]) + int'(rs[RES_BW*j +: RES_BW])) % 65536;
            if (RELU && v >= 32768) v = 0;
            w[PSUM_BW*j +: PSUM_BW] = 16'(v);
        end
        return w;
    endfunction

    // SRAM models: one-cycle read latency, garbage when not enabled.
    initial begin : sram_model
        logic             ocen, rcen;
        logic [ROW_W-1:0] oaddr;
        logic [ADDR_W-1:0] raddr;
        int               tile;
        op_q  = GARBAGE_OP;
        res_q = GARBAGE_RES;
        forever begin
            @(posedge clk);
            ocen  = op_cen;
            oaddr = op_addr;
            rcen  = res_cen;
            raddr = res_addr;
            tile  = core_begins - base - 1;
            #1;
            op_q  = ocen ? GARBAGE_OP  : op_word(tile * ROWS + int'(oaddr));
            res_q = rcen ? GARBAGE_RES : res_word(int'(raddr));
        end
    end

    // Core model: answers each core_begin CORE_LAT cycles later when enabled.
    initial begin : core_model
        core_done_model = 1'b0;
        forever begin
            @(negedge clk);
            if (core_begin) begin
                core_begins++;
                if (core_respond) begin
                    repeat (CORE_LAT) @(posedge clk);
                    #1 core_done_model = 1'b1;
                    @(posedge clk);
                    #1 core_done_model = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every presented row against the scoreboard head and
    // pops it on handshake; also checks the done pulse after the last row.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                if (expect_done) begin
                    check("done_after_last_row", done, 1);
                    check("busy_low_with_done", busy, 0);
                    expect_done = 1'b0;
                end
                if (done) done_pulses++;
                if (out_if.out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_row: got addr %0h expected no row", out_if.out_addr);
                    end else begin
                        check("row_addr", out_if.out_addr, exp_q[0].addr);
                        check("row_data", out_if.out_data, exp_q[0].data);
                        check("row_tile_idx", tile_idx, exp_q[0].addr / ROWS);
                        if (out_if.out_ready) begin
                            rows_seen++;
                            if (int'(exp_q[0].addr) == TOTAL_ROWS - 1) expect_done = 1'b1;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic push_run();
        exp_row_t e;
        for (int g = 0; g < TOTAL_ROWS; g++) begin
            e.addr = ADDR_W'(g);
            e.data = exp_word(g);
            exp_q.push_back(e);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge of the KICK cycle.
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_row(input int addr, input int limit, input string name);
        bit found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            @(negedge clk);
            if (out_if.out_valid && int'(out_if.out_addr) == addr) found = 1'b1;
        end
        if (!found) fail_now(name);
    endtask

    task automatic wait_valid(input int limit, input string name);
        bit found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            @(negedge clk);
            if (out_if.out_valid) found = 1'b1;
        end
        if (!found) fail_now(name);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_tile_idx"}, tile_idx, 0);
        check({tag, "_core_begin"}, core_begin, 0);
        check({tag, "_op_cen"}, op_cen, 1);
        check({tag, "_op_wen"}, op_wen, 1);
        check({tag, "_op_addr"}, op_addr, 0);
        check({tag, "_res_cen"}, res_cen, 1);
        check({tag, "_res_addr"}, res_addr, 0);
        check({tag, "_out_valid"}, out_if.out_valid, 0);
        check({tag, "_out_data"}, out_if.out_data, 0);
        check({tag, "_out_addr"}, out_if.out_addr, 0);
    endtask

    initial begin : stimulus
        int n;
        bit got;
        reset           = 1'b0;
        start           = 1'b0;
        core_done_extra = 1'b0;
        core_respond    = 1'b1;
        out_if.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Full run with one backpressure window on global row 35.
        push_run();
        base = core_begins;
        pulse_start();
        check("kick_busy", busy, 1);
        check("kick_core_begin", core_begin, 1);
        check("kick_op_wen", op_wen, 1);

        wait_row(34, 2000, "wait_row34");
        @(posedge clk);
        #1 out_if.out_ready = 1'b0;
        wait_valid(20, "wait_row35");
        for (int i = 0; i < 7; i++) begin
            check("stall_valid", out_if.out_valid, 1);
            check("stall_addr", out_if.out_addr, 35);
            check("stall_op_cen", op_cen, 1);
            check("stall_row_held", op_addr, 3);
            @(posedge clk);
            if (i < 6) @(negedge clk);
        end
        #1 out_if.out_ready = 1'b1;

        got = 1'b0;
        for (int k = 0; k < 10000 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) fail_now("wait_done_full_run");
        @(negedge clk);
        check("done_single_cycle", done, 0);
        check("full_core_begins", core_begins - base, NUM_TILES);
        check("full_rows_seen", rows_seen, TOTAL_ROWS);
        check("full_queue_empty", exp_q.size(), 0);
        check("full_done_pulses", done_pulses, 1);
        check("full_err_timeout", err_timeout, 0);
        check("full_idle_busy", busy, 0);

        // Timeout: core never answers.
        core_respond = 1'b0;
        base = core_begins;
        pulse_start();
        n = 0;
        got = 1'b0;
        while (n < TIMEOUT + 64 && !got) begin
            @(negedge clk);
            n++;
            if (err_timeout) got = 1'b1;
        end
        check("timeout_cycles", n, TIMEOUT + 1);
        check("timeout_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("timeout_sticky", err_timeout, 1);
        check("timeout_no_done", done_pulses, 1);
        check("timeout_single_kick", core_begins - base, 1);

        // Restart clears the error; abort mid-PUSH on tile 5.
        core_respond = 1'b1;
        push_run();
        base = core_begins;
        pulse_start();
        check("restart_err_cleared", err_timeout, 0);
        check("restart_core_begin", core_begin, 1);

        wait_row(5 * ROWS + 2, 2000, "wait_row82");
        @(posedge clk);
        #1 out_if.out_ready = 1'b0;
        wait_valid(20, "wait_row83");
        @(posedge clk);
        #1 begin
            start           = 1'b1;
            core_done_extra = 1'b1;
        end
        @(posedge clk);
        #1 begin
            start           = 1'b0;
            core_done_extra = 1'b0;
        end
        @(negedge clk);
        check("ignore_valid", out_if.out_valid, 1);
        check("ignore_addr", out_if.out_addr, 5 * ROWS + 3);
        check("ignore_tile", tile_idx, 5);
        check("ignore_busy", busy, 1);
        check("ignore_no_kick", core_begins - base, 6);

        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("abort");
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        out_if.out_ready = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_rekick", core_begins - base, 6);
        check("abort_idle", busy, 0);
        check("abort_no_valid", out_if.out_valid, 0);
        check("abort_no_done", done_pulses, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
